// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass, an optional
// hard-wired zero register, and a post-reset clear sweep gated by 'ready'.

// One read port: storage lookup, then bypass from same-cycle writes.
module regfile_mp_rd #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                        ready,
  input  logic [AW-1:0]               raddr,
  input  logic [NREGS-1:0][XLEN-1:0]  mem,
  input  logic [NUM_WR-1:0]           we,
  input  logic [NUM_WR*AW-1:0]        waddr,
  input  logic [NUM_WR*XLEN-1:0]      wdata,
  output logic [XLEN-1:0]             rdata
);
  // Ascending port scan so the highest-indexed matching writer wins.
  always_comb begin
    rdata = '0;
    if (ready) begin
      rdata = mem[raddr];
      for (int j = 0; j < NUM_WR; j++)
        if (we[j] && (waddr[j*AW +: AW] == raddr))
          rdata = wdata[j*XLEN +: XLEN];
      if ((ZERO_REG != 0) && (raddr == '0))
        rdata = '0;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*XLEN-1:0]   wdata,
  output logic                     ready,
  output logic                     clr_busy
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state, state_n;
  logic [AW-1:0]              idx;
  logic [NREGS-1:0][XLEN-1:0] mem;

  assign ready    = (state == RUN);
  assign clr_busy = ~ready;

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_n;
  end

  // Leave CLEAR on the edge that clears the last entry.
  always_comb begin
    state_n = state;
    if ((state == CLEAR) && (idx == AW'(NREGS-1)))
      state_n = RUN;
  end

  // Sweep index; wraps to 0 on the final clear and then holds in RUN.
  always_ff @(posedge clk) begin
    if (rst)                 idx <= '0;
    else if (state == CLEAR) idx <= idx + 1'b1;
  end

  // Storage: sweep writes in CLEAR, port writes in RUN (later port wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[idx] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++)
          if (we[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0)))
            mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rd #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .ready (ready),
      .raddr (raddr[i*AW +: AW]),
      .mem   (mem),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[i*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default config (ZERO_REG=1, one write port) and a
// two-write-port config with ZERO_REG=0, sharing clock and reset.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: defaults
  logic [9:0]  raddr0;
  logic [63:0] rdata0;
  logic [0:0]  we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        ready0, busy0;

  // dut1: NUM_WR=2, ZERO_REG=0
  logic [9:0]  raddr1;
  logic [63:0] rdata1;
  logic [1:0]  we1;
  logic [9:0]  waddr1;
  logic [63:0] wdata1;
  logic        ready1, busy1;

  int checks = 0;
  int errors = 0;

  regfile_mp u_dut0 (
    .clk(clk), .rst(rst), .raddr(raddr0), .rdata(rdata0), .we(we0),
    .waddr(waddr0), .wdata(wdata0), .ready(ready0), .clr_busy(busy0)
  );

  regfile_mp #(.NUM_WR(2), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .rst(rst), .raddr(raddr1), .rdata(rdata1), .we(we1),
    .waddr(waddr1), .wdata(wdata1), .ready(ready1), .clr_busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after rst release until dut0 ready rises (bounded).
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'd32);
  endtask

  initial begin
    rst = 1'b1;
    raddr0 = '0; we0 = '0; waddr0 = '0; wdata0 = '0;
    raddr1 = '0; we1 = '0; waddr1 = '0; wdata1 = '0;
    repeat (3) tick();

    // Reset state
    raddr0 = {5'd2, 5'd1};
    #1;
    chk("rst_ready", 64'(ready0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_rdata", rdata0, 64'd0);
    chk("rst_ready1", 64'(ready1), 64'd0);

    // Sweep: ready rises on the 32nd edge after release
    rst = 1'b0;
    wait_ready("sweep_len");
    chk("sweep_ready1", 64'(ready1), 64'd1);
    chk("sweep_busy", 64'(busy0), 64'd0);
    for (int r = 1; r < 32; r++) begin
      raddr0 = {5'd0, 5'(r)};
      #1;
      chk("clear_x", 64'(rdata0[31:0]), 64'd0);
    end

    // Basic write with bypass, then storage read on both ports
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr0 = {5'd6, 5'd5};
    #1;
    chk("bypass_p0", rdata0, {32'h0, 32'hDEADBEEF});
    tick();
    we0 = 1'b0; raddr0 = {5'd5, 5'd5};
    #1;
    chk("stored_both", rdata0, {32'hDEADBEEF, 32'hDEADBEEF});

    // Zero register, ZERO_REG=1
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h12345678; raddr0 = {5'd5, 5'd0};
    #1;
    chk("x0_bypass", rdata0, {32'hDEADBEEF, 32'h0});
    tick();
    we0 = 1'b0;
    #1;
    chk("x0_stored", 64'(rdata0[31:0]), 64'd0);

    // Zero register, ZERO_REG=0
    we1 = 2'b01; waddr1 = {5'd0, 5'd0}; wdata1 = {32'h0, 32'h12345678}; raddr1 = '0;
    tick();
    we1 = '0;
    #1;
    chk("x0_plain", 64'(rdata1[31:0]), 64'h12345678);

    // Write collision, highest port wins
    we1 = 2'b11; waddr1 = {5'd7, 5'd7}; wdata1 = {32'h22222222, 32'h11111111};
    raddr1 = {5'd0, 5'd7};
    #1;
    chk("coll_bypass", rdata1, {32'h12345678, 32'h22222222});
    tick();
    we1 = '0;
    #1;
    chk("coll_stored", 64'(rdata1[31:0]), 64'h22222222);

    // Mid-sweep reset restarts from index 0
    we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hCAFEF00D;
    tick();
    we0 = 1'b0; raddr0 = {5'd0, 5'd20};
    #1;
    chk("x20_pre", 64'(rdata0[31:0]), 64'hCAFEF00D);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    chk("mid_not_ready", 64'(ready0), 64'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_ready("mid_sweep_len");
    #1;
    chk("x20_cleared", 64'(rdata0[31:0]), 64'd0);

    // Writes ignored during clear
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAAAA5555; raddr0 = {5'd3, 5'd3};
    #1;
    chk("clr_read0", rdata0, 64'd0);
    tick();
    we0 = 1'b0;
    // one edge already used after release plus the write edge: 30 remain
    begin
      int n;
      n = 0;
      while (!ready0 && n < 100) begin
        tick();
        n++;
      end
      chk("clr_sweep_rest", 64'(n), 64'd30);
    end
    #1;
    chk("x3_cleared", rdata0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
